// File: rtl/data_memory_pkg.sv
// data_memory_pkg: control word layout and access-size encodings shared by the memory stage
package data_memory_pkg;

    localparam int CONTROL_BITS   = 8;
    localparam int REG_WE         = 0;
    localparam int MEM_WE         = 1;
    localparam int MEM_RE         = 2;
    localparam int ACCESS_SIZE_b1 = 3;
    localparam int ACCESS_SIZE_b2 = 4;
    localparam int LOAD_UNSIGNED  = 5;

    typedef logic [CONTROL_BITS-1:0] control_t;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // {b1,b2} pair taken from the control word
    function automatic logic [1:0] access_size(control_t c);
        return {c[ACCESS_SIZE_b1], c[ACCESS_SIZE_b2]};
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: execute-to-writeback bus through the memory stage
interface data_memory_if;
    import data_memory_pkg::*;

    logic [0:31] mem_address;
    logic [0:31] mem_data_in;
    logic [4:0]  rd_in;
    control_t    control_in;
    logic [0:31] mem_data_out;
    logic [0:31] rd_data_out;
    logic [4:0]  rd_out;
    control_t    control_out;

    modport master (
        output mem_address, mem_data_in, rd_in, control_in,
        input  mem_data_out, rd_data_out, rd_out, control_out
    );

    modport slave (
        input  mem_address, mem_data_in, rd_in, control_in,
        output mem_data_out, rd_data_out, rd_out, control_out
    );

endinterface

// File: rtl/data_memory_byte_ram.sv
// byte_ram: word-organised big-endian byte storage with per-lane write enables, lane 0 = bits [0:7]
module byte_ram #(
    parameter int WORDS = 262144
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [0:3]               we_mask,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [0:31]              wdata,
    output logic [0:31]              rdata
);

    logic [0:31] mem [WORDS];

    assign rdata = mem[addr];

    // write only the enabled byte lanes; untouched lanes keep their contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && we_mask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: pipeline memory stage with big-endian byte/half/word load-store and registered outputs
module data_memory
    import data_memory_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
    parameter int          MEM_BYTES = 1048576
) (
    input  logic           clk,
    input  logic           rst_n,
    data_memory_if.slave   bus
);

    localparam int AW = $clog2(MEM_BYTES) - 2;

    logic [31:0]   offset;
    logic [1:0]    lane;
    logic [AW-1:0] word_addr;
    logic [1:0]    size;
    logic          in_range;
    logic          access;
    logic          store;
    logic          load;
    logic [0:3]    we_mask;
    logic [0:31]   wdata;
    logic [0:31]   rword;
    logic [0:7]    bval;
    logic [0:15]   hval;
    logic          ext;
    logic [0:31]   load_data;

    // decode address/size into byte lanes, replicate store data, and extend load data
    always_comb begin
        offset    = bus.mem_address - BASE_ADDR;
        lane      = offset[1:0];
        word_addr = offset[AW+1:2];
        in_range  = offset < 32'(MEM_BYTES);
        size      = access_size(bus.control_in);
        access    = in_range && size != SIZE_NONE;
        store     = access && bus.control_in[MEM_WE];
        load      = access && bus.control_in[MEM_RE] && !bus.control_in[MEM_WE];
        we_mask   = size == SIZE_WORD ? 4'b1111 :
                    size == SIZE_HALF ? (lane[1] ? 4'b0011 : 4'b1100) :
                    4'b1000 >> lane;
        wdata     = size == SIZE_WORD ? bus.mem_data_in :
                    size == SIZE_HALF ? {2{bus.mem_data_in[16:31]}} :
                    {4{bus.mem_data_in[24:31]}};
        bval      = rword[{lane, 3'b000} +: 8];
        hval      = rword[{lane[1], 4'b0000} +: 16];
        ext       = !bus.control_in[LOAD_UNSIGNED] && (size == SIZE_HALF ? hval[0] : bval[0]);
        load_data = !load             ? 32'h0 :
                    size == SIZE_WORD ? rword :
                    size == SIZE_HALF ? {{16{ext}}, hval} :
                    {{24{ext}}, bval};
    end

    // array writes are suppressed while reset is held
    byte_ram #(.WORDS(MEM_BYTES / 4)) u_ram (
        .clk     (clk),
        .we      (store && rst_n),
        .we_mask (we_mask),
        .addr    (word_addr),
        .wdata   (wdata),
        .rdata   (rword)
    );

    // single pipeline stage toward writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_data_out <= '0;
            bus.rd_data_out  <= '0;
            bus.rd_out       <= '0;
            bus.control_out  <= '0;
        end else begin
            bus.mem_data_out <= load_data;
            bus.rd_data_out  <= bus.mem_address;
            bus.rd_out       <= bus.rd_in;
            bus.control_out  <= bus.control_in;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed load/store vectors with hand-computed expectations
module tb_data_memory;
    import data_memory_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    data_memory_if bus();

    data_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic control_t ctl(input bit we, input bit re, input bit [1:0] sz, input bit uns, input bit rw);
        control_t c;
        c = '0;
        c[MEM_WE] = we;
        c[MEM_RE] = re;
        c[ACCESS_SIZE_b1] = sz[1];
        c[ACCESS_SIZE_b2] = sz[0];
        c[LOAD_UNSIGNED] = uns;
        c[REG_WE] = rw;
        return c;
    endfunction

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r, input control_t c);
        bus.mem_address = a;
        bus.mem_data_in = d;
        bus.rd_in = r;
        bus.control_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input bit [1:0] sz);
        op(a, d, 5'd0, ctl(1, 0, sz, 0, 0));
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input bit [1:0] sz, input bit uns, input logic [31:0] exp);
        op(a, 32'hA5A5A5A5, 5'd3, ctl(0, 1, sz, uns, 1));
        check(tag, bus.mem_data_out, exp);
    endtask

    initial begin
        bus.mem_address = '0;
        bus.mem_data_in = '0;
        bus.rd_in = '0;
        bus.control_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_data", bus.mem_data_out, 0);
        check("rst_rd_data", bus.rd_data_out, 0);
        check("rst_rd", 32'(bus.rd_out), 0);
        check("rst_ctl", 32'(bus.control_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        st(32'h8002_0000, 32'h1234_5678, SIZE_WORD);
        check("sw_mem_data_zero", bus.mem_data_out, 0);
        check("sw_rd_data", bus.rd_data_out, 32'h8002_0000);
        ld("lw", 32'h8002_0000, SIZE_WORD, 0, 32'h1234_5678);
        check("lw_ctl", 32'(bus.control_out), 32'(ctl(0, 1, SIZE_WORD, 0, 1)));
        check("lw_rd", 32'(bus.rd_out), 3);
        ld("lb0", 32'h8002_0000, SIZE_BYTE, 0, 32'h0000_0012);
        ld("lb3", 32'h8002_0003, SIZE_BYTE, 0, 32'h0000_0078);
        st(32'h8002_0001, 32'hFFFF_FF80, SIZE_BYTE);
        ld("lb1", 32'h8002_0001, SIZE_BYTE, 0, 32'hFFFF_FF80);
        ld("lbu1", 32'h8002_0001, SIZE_BYTE, 1, 32'h0000_0080);
        ld("lw_after_sb", 32'h8002_0000, SIZE_WORD, 0, 32'h1280_5678);
        ld("lh2", 32'h8002_0002, SIZE_HALF, 0, 32'h0000_5678);
        ld("lh3_align", 32'h8002_0003, SIZE_HALF, 0, 32'h0000_5678);
        st(32'h8002_0000, 32'h0000_ABCD, SIZE_HALF);
        ld("lw_after_sh", 32'h8002_0000, SIZE_WORD, 0, 32'hABCD_5678);
        ld("lh0_signed", 32'h8002_0000, SIZE_HALF, 0, 32'hFFFF_ABCD);
        ld("lhu0", 32'h8002_0000, SIZE_HALF, 1, 32'h0000_ABCD);
        ld("lw_align", 32'h8002_0003, SIZE_WORD, 0, 32'hABCD_5678);

        op(32'h0000_002A, 32'hFFFF_FFFF, 5'd5, ctl(0, 0, SIZE_NONE, 0, 1));
        check("alu_rd_data", bus.rd_data_out, 32'h0000_002A);
        check("alu_rd", 32'(bus.rd_out), 5);
        check("alu_ctl", 32'(bus.control_out), 32'(ctl(0, 0, SIZE_NONE, 0, 1)));
        check("alu_mem_data", bus.mem_data_out, 0);
        op(32'h8002_0000, 32'h0, 5'd1, ctl(0, 0, SIZE_WORD, 0, 1));
        check("no_re_zero", bus.mem_data_out, 0);
        op(32'h8002_0000, 32'h0, 5'd1, ctl(1, 1, SIZE_WORD, 0, 0));
        check("we_re_zero", bus.mem_data_out, 0);
        ld("we_re_stored", 32'h8002_0000, SIZE_WORD, 0, 32'h0000_0000);

        st(32'h800F_FFFC, 32'h1122_3344, SIZE_WORD);
        ld("lw_top", 32'h800F_FFFC, SIZE_WORD, 0, 32'h1122_3344);
        st(32'h7FFF_FFFC, 32'hDEAD_BEEF, SIZE_WORD);
        ld("lw_below", 32'h7FFF_FFFC, SIZE_WORD, 0, 32'h0);
        ld("top_intact", 32'h800F_FFFC, SIZE_WORD, 0, 32'h1122_3344);
        st(32'h8012_0000, 32'hDEAD_BEEF, SIZE_WORD);
        ld("lw_above", 32'h8012_0000, SIZE_WORD, 0, 32'h0);
        ld("base_intact", 32'h8002_0000, SIZE_WORD, 0, 32'h0000_0000);

        st(32'h8002_0000, 32'h1234_5678, SIZE_WORD);
        ld("lw_reload", 32'h8002_0000, SIZE_WORD, 0, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        check("async_mem_data", bus.mem_data_out, 0);
        check("async_rd_data", bus.rd_data_out, 0);
        check("async_rd", 32'(bus.rd_out), 0);
        check("async_ctl", 32'(bus.control_out), 0);
        bus.mem_address = 32'h8002_0000;
        bus.mem_data_in = 32'hCAFE_BABE;
        bus.control_in = ctl(1, 0, SIZE_WORD, 0, 0);
        @(posedge clk);
        #1;
        check("held_mem_data", bus.mem_data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ld("lw_post_rst", 32'h8002_0000, SIZE_WORD, 0, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h8002_0000, byte address of the first memory location.
REQ-002 Parameter: MEM_BYTES, default 1048576, memory size in bytes, a power of two.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_address  in  32 [0:31]  byte address for load/store, also the ALU result passed through.
REQ-006 mem_data_in  in  32  store data (rt value), right-justified for byte/half stores.
REQ-007 rd_in  in  5  destination register number of the instruction.
REQ-008 control_in  in  CONTROL_BITS  control word from the execute stage.
REQ-009 mem_data_out  out  32  registered load data.
REQ-010 rd_data_out  out  32  registered copy of mem_address (ALU result for non-load writeback).
REQ-011 rd_out  out  5  registered rd_in.
REQ-012 control_out  out  CONTROL_BITS  registered control_in.

Function
REQ-013 Control fields used: MEM_WE (store), MEM_RE (load), ACCESS_SIZE_b1/b2, LOAD_UNSIGNED; all others pass through untouched.
REQ-014 Access size {b1,b2}: 11 = word, 10 = halfword, 01 = byte, 00 = no memory access (MEM_WE/MEM_RE ignored).
REQ-015 Byte order big-endian: the byte at the lowest address maps to bits [0:7]; bit 0 is MSB.
REQ-016 Alignment: word accesses ignore address bits [30:31]; halfword accesses ignore bit [31].
REQ-017 Store: when MEM_WE=1, the addressed bytes are written at the rising edge; byte uses mem_data_in[24:31]; halfword uses [16:31]; other bytes are unchanged.
REQ-018 Load: when MEM_RE=1 and MEM_WE=0, mem_data_out is set at the next rising edge to the addressed data.
REQ-019 Load extension: byte/halfword loads are sign-extended, or zero-extended when LOAD_UNSIGNED=1.
REQ-020 Loads with MEM_RE=0 set mem_data_out to 0.
REQ-021 MEM_WE=1 takes precedence: a store never updates mem_data_out except to 0.
REQ-022 Latency: every output reflects the inputs sampled at the previous rising edge (one pipeline stage); no stalls, no handshake.
REQ-023 Range: address offset (mem_address − BASE_ADDR) outside [0, MEM_BYTES) → store ignored, load returns 0; offset computed modulo 2^32.
REQ-024 Back-to-back store then load to the same address on consecutive cycles returns the newly stored data.
REQ-025 The same ports load the program image before execution (word stores, size 11); no separate load path exists.

Reset
REQ-026 rst_n low asynchronously clears mem_data_out, rd_data_out, rd_out and control_out to 0.
REQ-027 Memory array contents are not cleared by reset, and no store occurs while rst_n is low.
REQ-028 After rst_n deasserts, the first rising edge behaves normally.

Structure
REQ-029 Shared package/header (control.vh) holds CONTROL_BITS, the field indices REG_WE, MEM_WE, MEM_RE, ACCESS_SIZE_b1, ACCESS_SIZE_b2 and LOAD_UNSIGNED, and the access-size encodings.
REQ-030 One sub-module, byte_ram: a byte-addressable big-endian storage array with a write-lane mask; the lane/extension logic and output registers stay in data_memory.

Verification
REQ-031 Store word 0x12345678 @0x80020000 (size 11, MEM_WE) then load word → mem_data_out=0x12345678 one cycle after the load.
REQ-032 Load byte @0x80020000 signed → 0x00000012; load byte @0x80020003 → 0x00000078; store byte 0xFFFFFF80 @0x80020001, then LB → 0xFFFFFF80 and LBU → 0x00000080.
REQ-033 Load halfword @0x80020002 after REQ-031 store → 0x00005678; store half 0x0000ABCD @0x80020000, load word → 0xABCD5678.
REQ-034 Non-memory op: mem_address=0x0000002A, rd_in=5, REG_WE=1 → next edge rd_data_out=0x2A, rd_out=5, control_out equals the input, mem_data_out=0.
REQ-035 Store to 0x7FFFFFFC (below base) → no array change; load there → 0.
REQ-036 Assert rst_n low mid-stream → all outputs 0 immediately; reload the REQ-031 address → 0x12345678 still present.
